test_module: RTL and testbench

Activity-tracker core for the pedometer (Fitbit replica) datapath. It contains an internal step-pulse generator whose rate is selected by `MODE`, counts steps in each one-second window, and accumulates the high-activity time. High-activity time is the number of seconds spent in qualifying runs of at least 60 consecutive seconds at ≥64 steps/s. The 14-bit `highatime` result feeds the display/mux stage.

---
 rtl/fitbit_pkg.sv | 24 ++
 rtl/step_pulse_gen.sv | 77 +++++++
 rtl/test_module.sv | 106 ++++++++++
 tb/tb_test_module.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fitbit_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fitbit_pkg
// Purpose  : Shared mode encodings, step rates and limits for the tracker.
// Revision : 1.0
// ============================================================================
package fitbit_pkg;

    typedef enum logic [1:0] {
        MODE_WALK   = 2'd0,
        MODE_JOG    = 2'd1,
        MODE_RUN    = 2'd2,
        MODE_HYBRID = 2'd3
    } mode_e;

    localparam int RATE_WALK     = 32;
    localparam int RATE_JOG      = 64;
    localparam int RATE_RUN      = 128;

    localparam int HIGHATIME_MAX = 9999;
    localparam int HAT_W         = 14;

endpackage
`default_nettype wire

// File: rtl/step_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : step_pulse_gen
// Purpose  : Mode-selected step pulse source (period counter + hybrid phase).
// Revision : 1.0
// ============================================================================
module step_pulse_gen
    import fitbit_pkg::*;
#(
    parameter int CLKS_PER_SEC = 100_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] MODE,
    input  logic       START,
    input  logic       sec_tick_i,
    output logic       step_o
);

    localparam int CNT_W = (CLKS_PER_SEC / RATE_WALK > 1) ? $clog2(CLKS_PER_SEC / RATE_WALK) : 1;
    localparam logic [CNT_W-1:0] LAST_WALK = CNT_W'(CLKS_PER_SEC / RATE_WALK - 1);
    localparam logic [CNT_W-1:0] LAST_JOG  = CNT_W'(CLKS_PER_SEC / RATE_JOG - 1);
    localparam logic [CNT_W-1:0] LAST_RUN  = CNT_W'(CLKS_PER_SEC / RATE_RUN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    mode_e            mode_q;
    mode_e            eff_mode;
    logic             mode_vld_q;
    logic             phase_q;
    logic             mode_chg;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] last;

    // The registered mode governs the current cycle so a change coincident
    // with the second tick still completes the old period.
    assign eff_mode = mode_vld_q ? mode_q : mode_e'(MODE);
    assign mode_chg = mode_vld_q && (mode_e'(MODE) != mode_q);

    always_comb begin
        case (eff_mode)
            MODE_WALK: last = LAST_WALK;
            MODE_JOG:  last = LAST_JOG;
            MODE_RUN:  last = LAST_RUN;
            default:   last = phase_q ? LAST_RUN : LAST_WALK;
        endcase
    end

    assign step_o = START && (cnt_q >= last);

    always_comb begin
        cnt_d = cnt_q;
        if (START) begin
            cnt_d = (step_o || mode_chg) ? '0 : cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt_q      <= '0;
            mode_q     <= MODE_WALK;
            mode_vld_q <= 1'b0;
            phase_q    <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (START) begin
                mode_q     <= mode_e'(MODE);
                mode_vld_q <= 1'b1;
            end
            if (sec_tick_i) begin
                phase_q <= ~phase_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/test_module.sv
`default_nettype none
// ============================================================================
// Module   : test_module
// Purpose  : Activity tracker: per-second step count, streak, high-activity time.
// Revision : 1.0
// ============================================================================
module test_module
    import fitbit_pkg::*;
#(
    parameter int CLKS_PER_SEC = 100_000_000,
    parameter int HIGH_THRESH  = 64,
    parameter int MIN_RUN      = 60
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [1:0]       MODE,
    input  logic             START,
    output logic [HAT_W-1:0] highatime
);

    localparam int SUM_W = HAT_W + 1;
    localparam int SEC_W = $clog2(CLKS_PER_SEC);

    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(CLKS_PER_SEC - 1);
    localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(1);
    localparam logic [8:0]       THRESH   = 9'(HIGH_THRESH);
    localparam logic [6:0]       RUN_LEN  = 7'(MIN_RUN);
    localparam logic [SUM_W-1:0] RUN_ADD  = SUM_W'(MIN_RUN);
    localparam logic [SUM_W-1:0] SUM_ONE  = SUM_W'(1);
    localparam logic [SUM_W-1:0] HAT_MAX  = SUM_W'(HIGHATIME_MAX);

    logic [SEC_W-1:0] sec_q, sec_d;
    logic             sec_tick;
    logic             step;
    logic [7:0]       steps_q, steps_d;
    logic [8:0]       steps_tot;
    logic             qual;
    logic [6:0]       streak_q, streak_d;
    logic [SUM_W-1:0] hat_add;
    logic [SUM_W-1:0] hat_sum;
    logic [HAT_W-1:0] hat_q, hat_d;

    step_pulse_gen #(
        .CLKS_PER_SEC (CLKS_PER_SEC)
    ) u_step_gen (
        .CLK        (CLK),
        .RESET      (RESET),
        .MODE       (MODE),
        .START      (START),
        .sec_tick_i (sec_tick),
        .step_o     (step)
    );

    assign sec_tick  = START && (sec_q == SEC_LAST);
    // A pulse landing on the tick belongs to the second that is ending.
    assign steps_tot = {1'b0, steps_q} + {8'd0, step};
    assign qual      = steps_tot >= THRESH;

    always_comb begin
        sec_d    = sec_q;
        steps_d  = steps_q;
        streak_d = streak_q;
        hat_add  = '0;
        if (START) begin
            sec_d = sec_tick ? '0 : sec_q + SEC_ONE;
        end
        if (sec_tick) begin
            steps_d = '0;
        end else if (step && (steps_q != 8'hFF)) begin
            steps_d = steps_q + 8'd1;
        end
        if (sec_tick) begin
            if (!qual) begin
                streak_d = '0;
            end else if (streak_q >= RUN_LEN) begin
                hat_add = SUM_ONE;
            end else if (streak_q + 7'd1 == RUN_LEN) begin
                // Completing the run credits every second of it at once.
                streak_d = RUN_LEN;
                hat_add  = RUN_ADD;
            end else begin
                streak_d = streak_q + 7'd1;
            end
        end
        hat_sum = {1'b0, hat_q} + hat_add;
        hat_d   = (hat_sum > HAT_MAX) ? HAT_MAX[HAT_W-1:0] : hat_sum[HAT_W-1:0];
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sec_q    <= '0;
            steps_q  <= '0;
            streak_q <= '0;
            hat_q    <= '0;
        end else begin
            sec_q    <= sec_d;
            steps_q  <= steps_d;
            streak_q <= streak_d;
            hat_q    <= hat_d;
        end
    end

    assign highatime = hat_q;

endmodule
`default_nettype wire

// File: tb/tb_test_module.sv
`default_nettype none
// ============================================================================
// Module   : tb_test_module
// Purpose  : Self-checking bench for test_module with a per-second reference model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_test_module;

    localparam int C = 128;

    logic        CLK   = 1'b0;
    logic        RESET = 1'b0;
    logic        START = 1'b0;
    logic [1:0]  MODE  = 2'd0;
    logic [13:0] highatime;

    test_module #(
        .CLKS_PER_SEC (C),
        .HIGH_THRESH  (64),
        .MIN_RUN      (60)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .MODE      (MODE),
        .START     (START),
        .highatime (highatime)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_chk  = 0;
    bit cmp_en = 1'b0;

    // Reference model: one "second" = C running cycles; a second qualifies
    // when its mode's step rate reaches 64; runs of length >= 60 earn time.
    int         m_sec    = 0;
    int         m_run    = 0;
    int         m_hat    = 0;
    int         m_phase  = 0;
    int         m_ticks  = 0;
    logic [1:0] m_mode   = 2'd0;

    function automatic int rate_of(input logic [1:0] m, input int ph);
        case (m)
            2'd0:    return 32;
            2'd1:    return 64;
            2'd2:    return 128;
            default: return (ph != 0) ? 128 : 32;
        endcase
    endfunction

    always @(posedge CLK) begin
        if (RESET && START) begin
            if (m_sec == C - 1) begin
                int add;
                if (rate_of(m_mode, m_phase) >= 64) m_run = m_run + 1;
                else                                m_run = 0;
                add     = (m_run == 60) ? 60 : ((m_run > 60) ? 1 : 0);
                m_hat   = (m_hat + add > 9999) ? 9999 : m_hat + add;
                m_phase = 1 - m_phase;
                m_sec   = 0;
                m_ticks = m_ticks + 1;
            end else begin
                m_mode = MODE;
                m_sec  = m_sec + 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge CLK) begin
        if (cmp_en) chk("model_track", int'(highatime), m_hat);
    end

    task automatic model_clear(input logic [1:0] m);
        m_sec   = 0;
        m_run   = 0;
        m_hat   = 0;
        m_phase = 0;
        m_mode  = m;
    endtask

    task automatic do_reset(input logic [1:0] m, input int cycles);
        @(negedge CLK);
        #2;
        RESET = 1'b0;
        MODE  = m;
        START = 1'b1;
        model_clear(m);
        #1;
        cmp_en = 1'b1;
        repeat (cycles) @(negedge CLK);
        chk("reset_value", int'(highatime), 0);
        RESET = 1'b1;
    endtask

    // Run until n more seconds have ended; the next mode is applied on the
    // cycle of the final tick so every following second starts aligned.
    task automatic run_secs(input int n, input logic [1:0] nxt, input bit rnd);
        int t0;
        int cyc;
        t0  = m_ticks;
        cyc = 0;
        while (!(m_sec == C - 1 && m_ticks == t0 + n - 1) && cyc < n * C * 20) begin
            START = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
            @(negedge CLK);
            cyc++;
        end
        MODE  = nxt;
        START = 1'b1;
        while (m_ticks != t0 + n && cyc < n * C * 20 + 4) begin
            @(negedge CLK);
            cyc++;
        end
        if (m_ticks != t0 + n) begin
            n_chk++;
            $display("FAIL run_secs_timeout: got %0d ticks expected %0d", m_ticks - t0, n);
        end
    endtask

    typedef struct {
        bit         rst;
        logic [1:0] mode;
        int         nsec;
        int         exp;
    } seg_t;

    localparam int NSEG = 10;
    seg_t tbl[NSEG];

    initial begin
        logic [1:0] nxt;

        tbl[0] = '{1'b1, 2'd0, 61, 0};   // walk never qualifies
        tbl[1] = '{1'b1, 2'd2, 59, 0};   // run streak 59
        tbl[2] = '{1'b0, 2'd0, 1,  0};   // one walk second breaks it
        tbl[3] = '{1'b0, 2'd2, 59, 0};
        tbl[4] = '{1'b0, 2'd2, 1,  60};  // fresh streak reaches 60
        tbl[5] = '{1'b1, 2'd3, 70, 0};   // hybrid alternates 32/128
        tbl[6] = '{1'b1, 2'd1, 59, 0};
        tbl[7] = '{1'b0, 2'd1, 1,  60};
        tbl[8] = '{1'b0, 2'd1, 1,  61};
        tbl[9] = '{1'b0, 2'd1, 9,  70};

        do_reset(2'd1, 10);

        for (int i = 0; i < NSEG; i++) begin
            if (tbl[i].rst) do_reset(tbl[i].mode, 10);
            nxt = tbl[i].mode;
            if (i < NSEG - 1) begin
                if (!tbl[i + 1].rst) nxt = tbl[i + 1].mode;
            end
            run_secs(tbl[i].nsec, nxt, 1'b0);
            chk($sformatf("seg%0d", i), int'(highatime), tbl[i].exp);
        end

        // Pause mid-second, then resume.
        repeat (50) @(negedge CLK);
        START = 1'b0;
        repeat (5000) @(negedge CLK);
        chk("pause_hold", int'(highatime), 70);
        START = 1'b1;
        run_secs(1, 2'd1, 1'b0);
        chk("resume_71", int'(highatime), 71);
        run_secs(1, 2'd1, 1'b0);
        chk("resume_72", int'(highatime), 72);

        // Saturation on the +1 path.
        @(negedge CLK);
        #1;
        force dut.hat_q = 14'd9997;
        m_hat = 9997;
        #1;
        release dut.hat_q;
        run_secs(2, 2'd1, 1'b0);
        chk("sat_plus1", int'(highatime), 9999);
        run_secs(1, 2'd0, 1'b0);
        chk("sat_hold", int'(highatime), 9999);
        run_secs(1, 2'd1, 1'b0);
        chk("sat_walk", int'(highatime), 9999);

        // Saturation on the +MIN_RUN path.
        @(negedge CLK);
        #1;
        force dut.hat_q = 14'd9950;
        m_hat = 9950;
        #1;
        release dut.hat_q;
        run_secs(59, 2'd1, 1'b0);
        chk("sat60_pre", int'(highatime), 9950);
        run_secs(1, 2'd1, 1'b0);
        chk("sat60", int'(highatime), 9999);

        // Asynchronous reset mid-second, then held for 2000 cycles.
        repeat (37) @(negedge CLK);
        #2;
        RESET = 1'b0;
        model_clear(MODE);
        #1;
        chk("async_reset", int'(highatime), 0);
        repeat (2000) @(negedge CLK);
        chk("reset_2000", int'(highatime), 0);
        RESET = 1'b1;

        // Randomised modes and pauses against the model.
        do_reset(2'd1, 10);
        run_secs(50, 2'd1, 1'b0);
        for (int s = 0; s < 20; s++) begin
            logic [1:0] nm;
            if ($urandom_range(0, 9) < 8) nm = ($urandom_range(0, 1) != 0) ? 2'd2 : 2'd1;
            else                          nm = ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd0;
            run_secs($urandom_range(1, 3), nm, 1'b1);
            chk("rand_seg", int'(highatime), m_hat);
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
